// File: rtl/parity_frame_ctrl.sv
// Frame-level controller around an 8-bit even-parity generator/checker.
// Accepts FRAME_LEN bytes over a valid/ready handshake, checks each byte's
// received parity, forwards it with regenerated parity through a one-entry
// output buffer, and keeps per-frame error statistics.
module parity_frame_ctrl #(
    parameter int FRAME_LEN = 16,
    parameter int CNT_W     = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    input  logic             in_parity,
    output logic             in_ready,
    output logic             out_valid,
    output logic [7:0]       out_data,
    output logic             out_parity,
    input  logic             out_ready,
    output logic             busy,
    output logic             frame_done,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] first_err_idx,
    output logic             err_flag
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_DRAIN  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] ERR_MAX  = '1;

    state_t           state_q;
    logic             out_valid_q;
    logic [7:0]       out_data_q;
    logic             out_parity_q;
    logic [CNT_W-1:0] err_count_q;
    logic [CNT_W-1:0] err_count_d;
    logic [CNT_W-1:0] first_err_idx_q;
    logic             err_flag_q;
    logic [CNT_W-1:0] byte_idx_q;

    logic             accept;
    logic             byte_err;
    logic             gen_parity;
    logic             out_fire;

    // Handshake decode, parity generation/check and saturating error count.
    always_comb begin
        in_ready    = (state_q == S_ACTIVE) && (!out_valid_q || out_ready);
        accept      = in_ready && in_valid && !abort;
        gen_parity  = ^in_data;
        byte_err    = ^{in_data, in_parity};
        out_fire    = out_valid_q && out_ready;
        err_count_d = err_count_q;
        if (err_count_q != ERR_MAX) begin
            err_count_d = err_count_q + 1'b1;
        end
    end

    // Frame sequencer, output buffer and statistics registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            out_valid_q     <= 1'b0;
            out_data_q      <= 8'h00;
            out_parity_q    <= 1'b0;
            err_count_q     <= '0;
            first_err_idx_q <= '0;
            err_flag_q      <= 1'b0;
            byte_idx_q      <= '0;
        end else begin
            // A completed output handshake empties the buffer unless refilled below.
            if (out_fire) begin
                out_valid_q <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q         <= S_ACTIVE;
                        err_count_q     <= '0;
                        first_err_idx_q <= '0;
                        err_flag_q      <= 1'b0;
                        byte_idx_q      <= '0;
                    end
                end

                S_ACTIVE: begin
                    if (abort) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                    end else if (accept) begin
                        out_data_q   <= in_data;
                        out_parity_q <= gen_parity;
                        out_valid_q  <= 1'b1;
                        byte_idx_q   <= byte_idx_q + 1'b1;
                        if (byte_err) begin
                            err_count_q <= err_count_d;
                            if (!err_flag_q) begin
                                first_err_idx_q <= byte_idx_q;
                                err_flag_q      <= 1'b1;
                            end
                        end
                        if (byte_idx_q == LAST_IDX) begin
                            state_q <= S_DRAIN;
                        end
                    end
                end

                S_DRAIN: begin
                    if (abort) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                    end else if (!out_valid_q || out_ready) begin
                        // Buffer is empty now or empties on this edge.
                        state_q <= S_DONE;
                    end
                end

                S_DONE: begin
                    state_q <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign out_valid     = out_valid_q;
    assign out_data      = out_data_q;
    assign out_parity    = out_parity_q;
    assign busy          = (state_q == S_ACTIVE) || (state_q == S_DRAIN);
    assign frame_done    = (state_q == S_DONE);
    assign err_count     = err_count_q;
    assign first_err_idx = first_err_idx_q;
    assign err_flag      = err_flag_q;

endmodule
